// File: rtl/sdram_req_scheduler_if.sv
// rtl/sdram_req_scheduler_if.sv - host request/response, controller and status signals of sdram_req_scheduler
interface sdram_req_scheduler_if #(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_AW     = 2
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [HADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic [HADDR_WIDTH-1:0] sd_wr_addr;
    logic [HADDR_WIDTH-1:0] sd_rd_addr;
    logic [DATA_WIDTH-1:0]  sd_wr_data;
    logic                   sd_wr_enable;
    logic                   sd_rd_enable;
    logic [DATA_WIDTH-1:0]  sd_rd_data;
    logic                   sd_rd_ready;
    logic                   sd_busy;
    logic [FIFO_AW:0]       fifo_level;
    logic                   sched_idle;
    logic                   timeout_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
               sd_rd_data, sd_rd_ready, sd_busy,
        output req_ready, rsp_valid, rsp_data, sd_wr_addr, sd_rd_addr, sd_wr_data,
               sd_wr_enable, sd_rd_enable, fifo_level, sched_idle, timeout_err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
               sd_rd_data, sd_rd_ready, sd_busy,
        input  req_ready, rsp_valid, rsp_data, sd_wr_addr, sd_rd_addr, sd_wr_data,
               sd_wr_enable, sd_rd_enable, fifo_level, sched_idle, timeout_err
    );
endinterface

// File: rtl/sdram_req_scheduler.sv
// rtl/sdram_req_scheduler.sv - in-order request FIFO and one-at-a-time issue FSM in front of the SDRAM controller
// Optional wait timeout enabled by defining SDRAM_SCHED_TIMEOUT_EN.
module sdram_req_scheduler #(
    parameter int HADDR_WIDTH    = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_AW        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_req_scheduler_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WR, S_WAIT_RD} state_t;
    state_t state, state_nxt;

    logic                   fifo_write [DEPTH];
    logic [HADDR_WIDTH-1:0] fifo_addr  [DEPTH];
    logic [DATA_WIDTH-1:0]  fifo_data  [DEPTH];
    logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
    logic [FIFO_AW:0]       level;

    logic                   head_write;
    logic [HADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]  head_data;

    logic                   rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;

    logic push, pop, rsp_blocked, capture, tmo_hit, tmo_take, tmo_rsp;

    assign bus.req_ready = (level != FULL_LEVEL);
    assign push          = bus.req_valid & bus.req_ready;
    assign rsp_blocked   = rsp_valid_q & ~bus.rsp_ready;
    // A read may not start while its response would have nowhere to land.
    assign pop = (state == S_IDLE) && (level != '0) && (fifo_write[rd_ptr] || !rsp_blocked);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= bus.req_write;
            fifo_addr[wr_ptr]  <= bus.req_addr;
            fifo_data[wr_ptr]  <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_write <= 1'b0;
            head_addr  <= '0;
            head_data  <= '0;
        end else if (pop) begin
            head_write <= fifo_write[rd_ptr];
            head_addr  <= fifo_addr[rd_ptr];
            head_data  <= fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        tmo_take  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.sd_busy) state_nxt = head_write ? S_WAIT_WR : S_WAIT_RD;
                else if (tmo_hit) begin
                    tmo_take  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_WR: begin
                if (!bus.sd_busy) state_nxt = S_IDLE;
                else if (tmo_hit) begin
                    tmo_take  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_RD: begin
                // The busy fall after read data is consumed in S_WAIT_WR.
                if (bus.sd_rd_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_WAIT_WR;
                end else if (tmo_hit) begin
                    tmo_take  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A read abandoned before its data arrived still answers, with zero data, to keep ordering.
    assign tmo_rsp = tmo_take && !head_write && (state == S_ISSUE || state == S_WAIT_RD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.sd_rd_data;
        end else if (tmo_rsp) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            if (state == S_IDLE || state_nxt != state) tmo_cnt <= '0;
            else                                       tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_take) tmo_err_q <= 1'b1;
        end
    end

    assign tmo_hit         = (state != S_IDLE) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = tmo_err_q;
`else
    logic unused_tmo;
    assign unused_tmo      = (TIMEOUT_CYCLES == 0);
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.sd_wr_enable = (state == S_ISSUE) &&  head_write;
    assign bus.sd_rd_enable = (state == S_ISSUE) && !head_write;
    assign bus.sd_wr_addr   = head_addr;
    assign bus.sd_rd_addr   = head_addr;
    assign bus.sd_wr_data   = head_data;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.fifo_level   = level;
    assign bus.sched_idle   = (level == '0) && (state == S_IDLE);
endmodule

// File: tb/tb_sdram_req_scheduler.sv
// tb/tb_sdram_req_scheduler.sv - directed and randomized bench for sdram_req_scheduler with a controller model
module tb_sdram_req_scheduler;
    localparam int AW  = 24;
    localparam int DW  = 16;
    localparam int FAW = 2;
`ifdef SDRAM_SCHED_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_req_scheduler_if #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_AW(FAW)) bus ();

    sdram_req_scheduler #(
        .HADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_AW(FAW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    int checks = 0;
    int errors = 0;

    txn_t          exp_txn[$];
    txn_t          issued[$];
    logic [DW-1:0] exp_rsp[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] sd_mem  [logic [AW-1:0]];

    bit hold_busy = 0, never_busy = 0, rand_ctl = 0, pending = 0;
    int refresh_delay = 0, ign_cnt = 0, ign_target = 0, busy_left = 0;
    int txn_count = 0, en_cycles = 0, rsp_mode = 0;
    txn_t cur;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: optional refresh stall, busy for a few cycles, rd_ready one cycle before busy falls.
    always @(negedge clk) begin
        logic wr_en, rd_en;
        txn_t e;
        if (!rst_n) begin
            bus.sd_busy     = 1'b0;
            bus.sd_rd_ready = 1'b0;
            bus.sd_rd_data  = '0;
            pending = 0;
            ign_cnt = 0;
            busy_left = 0;
        end else begin
            wr_en = bus.sd_wr_enable;
            rd_en = bus.sd_rd_enable;
            en_cycles += int'(wr_en | rd_en);
            chk("both_enables", 32'(wr_en & rd_en), 0);
            bus.sd_rd_ready = 1'b0;
            if (bus.sd_busy) begin
                chk("enable_during_busy", {30'b0, wr_en, rd_en}, 0);
                if (!hold_busy) begin
                    busy_left--;
                    if (busy_left == 1 && !cur.w) begin
                        bus.sd_rd_ready = 1'b1;
                        bus.sd_rd_data  = sd_mem.exists(cur.a) ? sd_mem[cur.a] : '0;
                    end
                    if (busy_left == 0) bus.sd_busy = 1'b0;
                end
            end else if ((wr_en || rd_en) && !never_busy) begin
                if (!pending) begin
                    pending    = 1;
                    ign_cnt    = 0;
                    ign_target = rand_ctl ? int'($urandom_range(0, 3)) : refresh_delay;
                end
                if (ign_cnt < ign_target) begin
                    ign_cnt++;
                end else begin
                    cur.w = wr_en;
                    cur.a = bus.sd_rd_addr;
                    cur.d = bus.sd_wr_data;
                    chk("issue_expected", 32'(exp_txn.size() != 0), 1);
                    if (exp_txn.size() != 0) begin
                        e = exp_txn.pop_front();
                        chk("issue_write", 32'(wr_en), 32'(e.w));
                        chk("issue_rd_addr", 32'(bus.sd_rd_addr), 32'(e.a));
                        chk("issue_wr_addr", 32'(bus.sd_wr_addr), 32'(e.a));
                        if (e.w) chk("issue_wdata", 32'(bus.sd_wr_data), 32'(e.d));
                    end
                    if (cur.w) sd_mem[cur.a] = cur.d;
                    issued.push_back(cur);
                    txn_count++;
                    pending     = 0;
                    busy_left   = rand_ctl ? int'($urandom_range(3, 6)) : 3;
                    bus.sd_busy = 1'b1;
                end
            end else if (!never_busy) begin
                chk("enable_dropped_before_busy", 32'(pending), 0);
            end
        end
    end

    always @(negedge clk) begin
        case (rsp_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        #1;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
            if (exp_rsp.size() != 0) chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp.pop_front()));
        end
    end

    task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        txn_t t;
        n = 0;
        while (!bus.req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t.w = w; t.a = a; t.d = d;
        exp_txn.push_back(t);
        if (w) ref_mem[a] = d;
        else   exp_rsp.push_back(ref_mem.exists(a) ? ref_mem[a] : '0);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(bus.sched_idle && !bus.sd_busy && exp_txn.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 2000), 1);
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.rsp_valid), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0, e0;
        logic [AW-1:0] pool [8];
        txn_t plan [5];

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int k = 0; k < 8; k++) pool[k] = AW'($urandom);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_fifo_level", 32'(bus.fifo_level), 0);
        chk("rst_sched_idle", 32'(bus.sched_idle), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_enables", {30'b0, bus.sd_wr_enable, bus.sd_rd_enable}, 0);
        chk("rst_sd_addr", 32'(bus.sd_wr_addr | bus.sd_rd_addr), 0);
        chk("rst_sd_wdata", 32'(bus.sd_wr_data), 0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 0);

        // single write
        rsp_mode = 1;
        t0 = txn_count; e0 = en_cycles;
        push(1'b1, 24'h012345, 16'hA5A5);
        wait_idle("t1_idle");
        chk("t1_txns", 32'(txn_count - t0), 1);
        chk("t1_wr_addr", 32'(issued[$].a), 32'h012345);
        chk("t1_wr_data", 32'(issued[$].d), 32'hA5A5);
        chk("t1_enable_cycles", 32'(en_cycles - e0), 1);
        chk("t1_sched_idle", 32'(bus.sched_idle), 1);

        // read returning 0xBEEF, held until taken
        sd_mem[24'h000010] = 16'hBEEF;
        ref_mem[24'h000010] = 16'hBEEF;
        rsp_mode = 0;
        push(1'b0, 24'h000010, 16'h0000);
        wait_rsp("t2_rsp_valid");
        chk("t2_rsp_data", 32'(bus.rsp_data), 32'hBEEF);
        repeat (5) @(negedge clk);
        chk("t2_rsp_held", 32'(bus.rsp_valid), 1);
        chk("t2_rsp_data_held", 32'(bus.rsp_data), 32'hBEEF);
        rsp_mode = 1;
        repeat (3) @(negedge clk);
        chk("t2_rsp_cleared", 32'(bus.rsp_valid), 0);
        chk("t2_rsp_drained", 32'(exp_rsp.size()), 0);

        // five back-to-back while the controller stays busy
        plan[0] = '{1'b1, 24'h000100, 16'h1111};
        plan[1] = '{1'b0, 24'h000200, 16'h0000};
        plan[2] = '{1'b1, 24'h000300, 16'h3333};
        plan[3] = '{1'b0, 24'h000100, 16'h0000};
        plan[4] = '{1'b1, 24'h000200, 16'h5555};
        hold_busy = 1;
        t0 = txn_count;
        for (int k = 0; k < 5; k++) push(plan[k].w, plan[k].a, plan[k].d);
        chk("t3_level_full", 32'(bus.fifo_level), 4);
        chk("t3_req_ready_full", 32'(bus.req_ready), 0);
        hold_busy = 0;
        wait_idle("t3_idle");
        chk("t3_txns", 32'(txn_count - t0), 5);
        for (int k = 0; k < 5; k++) begin
            chk("t3_order_write", 32'(issued[t0 + k].w), 32'(plan[k].w));
            chk("t3_order_addr", 32'(issued[t0 + k].a), 32'(plan[k].a));
        end

        // refresh collision: enable ignored for 6 cycles
        refresh_delay = 6;
        t0 = txn_count; e0 = en_cycles;
        push(1'b1, 24'h000400, 16'h4444);
        wait_idle("t4_idle");
        chk("t4_enable_cycles", 32'(en_cycles - e0), 7);
        chk("t4_txns", 32'(txn_count - t0), 1);
        refresh_delay = 0;

        // second read held back while the response slot is full
        rsp_mode = 0;
        t0 = txn_count;
        push(1'b0, 24'h000100, 16'h0000);
        push(1'b0, 24'h000300, 16'h0000);
        wait_rsp("t5_rsp_valid");
        repeat (10) @(negedge clk);
        chk("t5_level_held", 32'(bus.fifo_level), 1);
        chk("t5_one_issue", 32'(txn_count - t0), 1);
        chk("t5_ctrl_idle", 32'(bus.sd_busy), 0);
        rsp_mode = 1;
        wait_idle("t5_idle");
        repeat (3) @(negedge clk);
        chk("t5_txns", 32'(txn_count - t0), 2);
        chk("t5_rsp_drained", 32'(exp_rsp.size()), 0);

        // randomized traffic against the reference memory and issue order
        rand_ctl = 1;
        rsp_mode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], DW'($urandom));
        end
        rsp_mode = 1;
        wait_idle("rand_idle");
        repeat (3) @(negedge clk);
        chk("rand_rsp_drained", 32'(exp_rsp.size()), 0);
        rand_ctl = 0;

        // reset mid-operation discards queued and in-flight work
        hold_busy = 1;
        push(1'b1, 24'h000600, 16'h6666);
        push(1'b0, 24'h000700, 16'h0000);
        push(1'b1, 24'h000800, 16'h8888);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        hold_busy = 0;
        rst_n = 1'b1;
        exp_txn.delete();
        exp_rsp.delete();
        ref_mem = sd_mem;
        @(negedge clk);
        chk("t7_level", 32'(bus.fifo_level), 0);
        chk("t7_sched_idle", 32'(bus.sched_idle), 1);
        chk("t7_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t7_req_ready", 32'(bus.req_ready), 1);
        chk("t7_enables", {30'b0, bus.sd_wr_enable, bus.sd_rd_enable}, 0);
        push(1'b0, 24'h000600, 16'h0000);
        wait_idle("t7_idle");
        repeat (3) @(negedge clk);
        chk("t7_rsp_drained", 32'(exp_rsp.size()), 0);

`ifdef SDRAM_SCHED_TIMEOUT_EN
        // controller never responds: read times out with a zero response
        never_busy = 1;
        rsp_mode = 0;
        e0 = en_cycles;
        push(1'b0, 24'h000900, 16'h0000);
        exp_txn.delete();
        exp_rsp.delete();
        exp_rsp.push_back('0);
        t0 = 0;
        while (!bus.timeout_err && t0 < 100) begin
            @(negedge clk);
            t0++;
        end
        chk("t8_timeout_err", 32'(bus.timeout_err), 1);
        chk("t8_enable_cycles", 32'(en_cycles - e0), 8);
        chk("t8_sched_idle", 32'(bus.sched_idle), 1);
        chk("t8_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("t8_rsp_data", 32'(bus.rsp_data), 0);
        rsp_mode = 1;
        repeat (3) @(negedge clk);
        chk("t8_rsp_drained", 32'(exp_rsp.size()), 0);
        push(1'b1, 24'h000A00, 16'h0001);
        push(1'b1, 24'h000A10, 16'h0002);
        chk("t8_level_before_reset", 32'(bus.fifo_level), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        never_busy = 0;
        exp_txn.delete();
        exp_rsp.delete();
        @(negedge clk);
        chk("t8_err_cleared", 32'(bus.timeout_err), 0);
        chk("t8_level_cleared", 32'(bus.fifo_level), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
